axi_stream_tp_chk: RTL and testbench
====================================

AXI_STREAM_TP_CHK -- requirements
Module: axi_stream_tp_chk

Interface
REQ-001 SHALL have exactly one clock and one reset; the reset is synchronous and active-high.
REQ-002 clk_i  in  1  single clock; all logic on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 s_tdata_i  in  8  pixel data.
REQ-005 s_tvalid_i  in  1  beat valid.
REQ-006 s_tready_o  out  1  beat accepted when s_tvalid_i && s_tready_o.
REQ-007 s_tuser_i  in  1  start-of-frame, on pixel 0 of line 0.
REQ-008 s_tlast_i  in  1  end-of-line, on the last pixel of each line.
REQ-009 chk_enable_i  in  1  run request; level-sensitive.
REQ-010 chk_width_i / chk_height_i  in  11 each  expected pixels per line / lines per frame.
REQ-011 frame_cnt_o  out  8  completed frames, wraps at 255->0.
REQ-012 err_cnt_o  out  16  erroneous beats, saturates at 0xFFFF.
REQ-013 err_flags_o  out  4  sticky: [0] data mismatch, [1] early TLAST, [2] missing TLAST, [3] unexpected/missing SOF.
REQ-014 busy_o  out  1  high when state is not IDLE.

Function
REQ-015 SHALL register chk_enable_i through a 2-stage history; start = rising edge of the registered enable.
REQ-016 On start: latch width/height, clear frame_cnt_o, err_cnt_o, err_flags_o and the pixel/line counters; config changes at any other time SHALL be ignored.
REQ-017 States: IDLE, WAIT_SOF, DATA. IDLE->WAIT_SOF on start; any state->IDLE within 2 cycles of chk_enable_i low.
REQ-018 s_tready_o SHALL be 0 in IDLE, and 1 in WAIT_SOF/DATA (subject to REQ-029).
REQ-019 WAIT_SOF: beats with s_tuser_i=0 are discarded without error; a beat with s_tuser_i=1 is checked as pixel 0 line 0, then DATA.
REQ-020 Expected data = {line[3:0], pixel[3:0]}; a mismatch on an accepted beat sets flag[0].
REQ-021 Pixel counter increments per accepted beat; at pixel==width-1 it wraps to 0 and the line counter increments.
REQ-022 s_tlast_i=1 with pixel<width-1: set flag[1], force pixel=0, increment line (resync).
REQ-023 s_tlast_i=0 at pixel==width-1: set flag[2], wrap per REQ-021.
REQ-024 In DATA, s_tuser_i=1 on a beat other than pixel 0 line 0: set flag[3], restart at pixel 0 line 0 with that beat as pixel 0; frame_cnt_o unchanged.
REQ-025 In DATA at pixel 0 line 0 with s_tuser_i=0: set flag[3], beat checked normally.
REQ-026 Last beat of line height-1 (after resync accounting): frame_cnt_o +1, counters cleared, ->WAIT_SOF.
REQ-027 err_cnt_o SHALL increment by exactly 1 per accepted beat with one or more errors; flags and counters update 1 cycle after the handshake.
REQ-028 width or height of 0 SHALL be treated as 1.

Reset
REQ-029 rst_i=1 SHALL force: state IDLE, s_tready_o=0, frame_cnt_o=0, err_cnt_o=0, err_flags_o=0, busy_o=0, enable history 0, latched config 0.
REQ-030 rst_i asserted mid-frame SHALL abort the frame with no count update; a new start is required after release.

Configuration
REQ-031 Macro TP_CHK_BACKPRESSURE_EN: when defined, s_tready_o in WAIT_SOF/DATA SHALL equal bit 0 of a 16-bit maximal-length LFSR (seed 0xACE1 on start, advances every cycle); when undefined, s_tready_o=1 in those states and no LFSR is built.
REQ-032 Check logic SHALL be identical with and without the macro; only beats with s_tvalid_i && s_tready_o are evaluated.

Verification
REQ-033 Width 4, height 2, 3 clean frames from a conforming source -> frame_cnt_o=3, err_cnt_o=0, err_flags_o=0.
REQ-034 Width 4, height 2, data of line 1 pixel 2 corrupted to 0xFF -> flag[0]=1, err_cnt_o=1, frame_cnt_o=1.
REQ-035 Width 8, TLAST on pixel 5 of line 0 -> flag[1]=1; the next beat is checked as line 1 pixel 0 (expected 0x10).
REQ-036 Second SOF at line 1 pixel 2 -> flag[3]=1, frame_cnt_o stays 0; the following clean frame gives frame_cnt_o=1.
REQ-037 chk_enable_i dropped mid-frame -> busy_o=0 and s_tready_o=0 within 2 cycles; re-enable clears all counters and flags.
REQ-038 With TP_CHK_BACKPRESSURE_EN defined, 10 clean 16x4 frames -> frame_cnt_o=10, err_cnt_o=0, s_tready_o observed low at least once.

Source files
------------

// File: rtl/axi_stream_tp_chk.sv
// AXI-Stream test-pattern checker.
// Checks an incoming pixel stream against the pattern {line[3:0], pixel[3:0]},
// tracks line/frame framing via TUSER (SOF) and TLAST (EOL), and accumulates
// frame count, error-beat count and sticky error flags.
// Optional build macro: TP_CHK_BACKPRESSURE_EN -- drives s_tready_o from a
// 16-bit LFSR while active, to exercise upstream backpressure.
module axi_stream_tp_chk (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  input  logic        s_tuser_i,
  input  logic        s_tlast_i,
  input  logic        chk_enable_i,
  input  logic [10:0] chk_width_i,
  input  logic [10:0] chk_height_i,
  output logic [7:0]  frame_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic [3:0]  err_flags_o,
  output logic        busy_o
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;

  logic [1:0]  state;
  logic [1:0]  en_hist;
  logic        start;
  logic [10:0] width;
  logic [10:0] height;
  logic [10:0] pix;
  logic [10:0] line;
  logic        ready_gen;

  logic        accept;
  logic        check_beat;
  logic        first_pos;
  logic [10:0] cur_pix;
  logic [10:0] cur_line;
  logic        last_pix;
  logic        line_end;
  logic        frame_done;
  logic [10:0] nxt_pix;
  logic [10:0] nxt_line;
  logic [3:0]  beat_flags;

  // en_hist[0] is the registered enable; start fires on its rising edge
  assign start = en_hist[0] & ~en_hist[1];

`ifdef TP_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1), reseeded on start
  always_ff @(posedge clk_i) begin
    if (rst_i || start) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign ready_gen = lfsr[0];
`else
  assign ready_gen = 1'b1;
`endif

  assign s_tready_o = (state != IDLE) && ready_gen;
  assign busy_o     = (state != IDLE);
  assign accept     = s_tvalid_i && s_tready_o;
  // WAIT_SOF silently drops beats until one carries SOF
  assign check_beat = accept && ((state == DATA) || s_tuser_i);
  assign first_pos  = (pix == '0) && (line == '0);

  // Per-beat evaluation: position resolution, error detection, next counters
  always_comb begin
    cur_pix    = pix;
    cur_line   = line;
    beat_flags = '0;
    // A SOF beat (expected or not) is always taken as pixel 0 of line 0
    if ((state == WAIT_SOF) || (s_tuser_i && !first_pos)) begin
      cur_pix  = '0;
      cur_line = '0;
    end
    if (state == DATA) begin
      beat_flags[3] = s_tuser_i ^ first_pos;
    end
    last_pix      = (cur_pix == width - 11'd1);
    beat_flags[0] = (s_tdata_i != {cur_line[3:0], cur_pix[3:0]});
    beat_flags[1] = s_tlast_i && !last_pix;
    beat_flags[2] = !s_tlast_i && last_pix;
    // Early TLAST resyncs to the next line just like a normal line end
    line_end      = s_tlast_i || last_pix;
    frame_done    = line_end && (cur_line == height - 11'd1);
    nxt_pix       = line_end ? '0 : cur_pix + 11'd1;
    if (frame_done) begin
      nxt_line = '0;
    end else if (line_end) begin
      nxt_line = cur_line + 11'd1;
    end else begin
      nxt_line = cur_line;
    end
  end

  // Control state, latched configuration, position counters and statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      en_hist     <= '0;
      width       <= '0;
      height      <= '0;
      pix         <= '0;
      line        <= '0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
      err_flags_o <= '0;
    end else begin
      en_hist <= {en_hist[0], chk_enable_i};
      if (!en_hist[0]) begin
        state <= IDLE;
      end else if (start) begin
        state       <= WAIT_SOF;
        width       <= (chk_width_i == '0) ? 11'd1 : chk_width_i;
        height      <= (chk_height_i == '0) ? 11'd1 : chk_height_i;
        pix         <= '0;
        line        <= '0;
        frame_cnt_o <= '0;
        err_cnt_o   <= '0;
        err_flags_o <= '0;
      end else if (check_beat) begin
        pix         <= nxt_pix;
        line        <= nxt_line;
        err_flags_o <= err_flags_o | beat_flags;
        if ((beat_flags != '0) && (err_cnt_o != '1)) begin
          err_cnt_o <= err_cnt_o + 16'd1;
        end
        if (frame_done) begin
          frame_cnt_o <= frame_cnt_o + 8'd1;
          state       <= WAIT_SOF;
        end else begin
          state <= DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_tp_chk.sv
// Self-checking bench for axi_stream_tp_chk: per-beat scoreboard of expected
// frame/error counters and flags, plus scenario-level checks.
module tb_axi_stream_tp_chk;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic        chk_enable = 1'b0;
  logic [10:0] chk_width = '0;
  logic [10:0] chk_height = '0;
  logic [7:0]  frame_cnt;
  logic [15:0] err_cnt;
  logic [3:0]  err_flags;
  logic        busy;

  typedef struct {
    logic [7:0]  f;
    logic [15:0] e;
    logic [3:0]  g;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   seen_not_ready = 1'b0;

  axi_stream_tp_chk dut (
    .clk_i(clk), .rst_i(rst),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
    .chk_enable_i(chk_enable), .chk_width_i(chk_width), .chk_height_i(chk_height),
    .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt), .err_flags_o(err_flags),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one beat, push its expected post-beat state, compare after acceptance
  task automatic send_beat(input logic [7:0] d, input logic u, input logic l,
                           input logic [7:0] ef, input logic [15:0] ee,
                           input logic [3:0] eg);
    exp_t x;
    bit   got;
    x.f = ef; x.e = ee; x.g = eg;
    sb.push_back(x);
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (s_tready) got = 1'b1;
      else if (busy) seen_not_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    x = sb.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL beat_accept_timeout data=%h ready=%b required ready=1", d, s_tready);
    end else if (frame_cnt !== x.f || err_cnt !== x.e || err_flags !== x.g) begin
      miscompares++;
      $display("FAIL beat_state data=%h got f=%0d e=%0d g=%b required f=%0d e=%0d g=%b",
               d, frame_cnt, err_cnt, err_flags, x.f, x.e, x.g);
    end
  endtask

  // Conforming frame; counters expected to sit at (f0, e0, g0) throughout
  task automatic send_frame(input int w, input int h, input logic [7:0] f0,
                            input logic [15:0] e0, input logic [3:0] g0);
    for (int ln = 0; ln < h; ln++) begin
      for (int px = 0; px < w; px++) begin
        logic [10:0] lv, pv;
        lv = 11'(ln); pv = 11'(px);
        send_beat({lv[3:0], pv[3:0]}, (ln == 0 && px == 0), (px == w - 1),
                  (ln == h - 1 && px == w - 1) ? f0 + 8'd1 : f0, e0, g0);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if (frame_cnt !== 8'd0 || err_cnt !== 16'd0 || err_flags !== 4'd0) begin
      miscompares++;
      $display("FAIL %s_cleared got f=%0d e=%0d g=%b required all 0", tag, frame_cnt, err_cnt, err_flags);
    end
  endtask

  task automatic start_run(input logic [10:0] w, input logic [10:0] h);
    bit ok;
    chk_enable = 1'b0;
    tick(3);
    chk_width = w; chk_height = h; chk_enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick(1);
      if (busy) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL start_busy got busy=%b required 1", busy);
    end
    check_cleared("start");
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    vectors++;
    if (s_tready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got ready=%b busy=%b required 0 0", s_tready, busy);
    end
    check_cleared("reset");
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_clean_frames;
    start_run(11'd4, 11'd2);
    chk_width = 11'd7; chk_height = 11'd3;   // must be ignored while running
    send_beat(8'h55, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);  // pre-SOF, discarded
    for (int f = 0; f < 3; f++) send_frame(4, 2, 8'(f), 16'd0, 4'd0);
    vectors++;
    if (frame_cnt !== 8'd3 || err_cnt !== 16'd0 || err_flags !== 4'd0) begin
      miscompares++;
      $display("FAIL clean_frames got f=%0d e=%0d g=%b required 3 0 0", frame_cnt, err_cnt, err_flags);
    end
  endtask

  task automatic test_data_error;
    start_run(11'd4, 11'd2);
    send_beat(8'h00, 1'b1, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h01, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h02, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h03, 1'b0, 1'b1, 8'd0, 16'd0, 4'd0);
    send_beat(8'h10, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h11, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'hFF, 1'b0, 1'b0, 8'd0, 16'd1, 4'b0001);
    send_beat(8'h13, 1'b0, 1'b1, 8'd1, 16'd1, 4'b0001);
  endtask

  task automatic test_early_tlast;
    start_run(11'd8, 11'd2);
    for (int p = 0; p < 5; p++)
      send_beat(8'(p), (p == 0), 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h05, 1'b0, 1'b1, 8'd0, 16'd1, 4'b0010);
    send_beat(8'h10, 1'b0, 1'b0, 8'd0, 16'd1, 4'b0010);
    for (int p = 1; p < 8; p++)
      send_beat(8'h10 | 8'(p), 1'b0, (p == 7), (p == 7) ? 8'd1 : 8'd0, 16'd1, 4'b0010);
  endtask

  task automatic test_second_sof;
    start_run(11'd4, 11'd2);
    for (int p = 0; p < 4; p++)
      send_beat(8'(p), (p == 0), (p == 3), 8'd0, 16'd0, 4'd0);
    send_beat(8'h10, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h11, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h00, 1'b1, 1'b0, 8'd0, 16'd1, 4'b1000);
    for (int p = 1; p < 4; p++)
      send_beat(8'(p), 1'b0, (p == 3), 8'd0, 16'd1, 4'b1000);
    for (int p = 0; p < 4; p++)
      send_beat(8'h10 | 8'(p), 1'b0, (p == 3), (p == 3) ? 8'd1 : 8'd0, 16'd1, 4'b1000);
  endtask

  task automatic test_missing_tlast;
    start_run(11'd4, 11'd1);
    send_beat(8'h00, 1'b1, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h01, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h02, 1'b0, 1'b0, 8'd0, 16'd0, 4'd0);
    // bad data and missing TLAST on one beat: one error count, two flags
    send_beat(8'hEE, 1'b0, 1'b0, 8'd1, 16'd1, 4'b0101);
    send_frame(4, 1, 8'd1, 16'd1, 4'b0101);
  endtask

  task automatic test_zero_cfg;
    start_run(11'd0, 11'd0);
    send_beat(8'h00, 1'b1, 1'b1, 8'd1, 16'd0, 4'd0);
    send_beat(8'h00, 1'b1, 1'b1, 8'd2, 16'd0, 4'd0);
  endtask

  task automatic test_disable;
    start_run(11'd4, 11'd2);
    send_beat(8'h00, 1'b1, 1'b0, 8'd0, 16'd0, 4'd0);
    send_beat(8'h77, 1'b0, 1'b0, 8'd0, 16'd1, 4'b0001);
    chk_enable = 1'b0;
    tick(2);
    vectors++;
    if (busy !== 1'b0 || s_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_idle got busy=%b ready=%b required 0 0", busy, s_tready);
    end
    start_run(11'd4, 11'd2);
    send_frame(4, 2, 8'd0, 16'd0, 4'd0);
  endtask

  task automatic test_midframe_reset;
    start_run(11'd4, 11'd1);
    send_beat(8'hFF, 1'b1, 1'b0, 8'd0, 16'd1, 4'b0001);
    rst = 1'b1;
    tick(1);
    vectors++;
    if (busy !== 1'b0 || s_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl got busy=%b ready=%b required 0 0", busy, s_tready);
    end
    check_cleared("midreset");
    rst = 1'b0;
    start_run(11'd4, 11'd1);
    send_frame(4, 1, 8'd0, 16'd0, 4'd0);
  endtask

`ifdef TP_CHK_BACKPRESSURE_EN
  task automatic test_backpressure;
    start_run(11'd16, 11'd4);
    seen_not_ready = 1'b0;
    for (int f = 0; f < 10; f++) send_frame(16, 4, 8'(f), 16'd0, 4'd0);
    vectors++;
    if (frame_cnt !== 8'd10 || err_cnt !== 16'd0 || seen_not_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure got f=%0d e=%0d lowseen=%b required 10 0 1",
               frame_cnt, err_cnt, seen_not_ready);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_clean_frames;
    test_data_error;
    test_early_tlast;
    test_second_sof;
    test_missing_tlast;
    test_zero_cfg;
    test_disable;
    test_midframe_reset;
`ifdef TP_CHK_BACKPRESSURE_EN
    test_backpressure;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
